// File: rtl/onewire_word_tx_if.sv
// Handshake and bus signals between the 1-Wire sequencer (master) and the word write engine (slave).
// With ONEWIRE_READ_EN defined the interface also carries rd_mode, bus_in and rd_data.
interface onewire_word_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic              bus_oe;
    logic              bus;
    logic [1:0]        fsm_state;
`ifdef ONEWIRE_READ_EN
    logic              rd_mode;
    logic              bus_in;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, tx_data, rd_mode, bus_in,
        input  busy, done, bus_oe, bus, fsm_state, rd_data
    );
    modport slave (
        input  start, tx_data, rd_mode, bus_in,
        output busy, done, bus_oe, bus, fsm_state, rd_data
    );
`else
    modport master (
        output start, tx_data,
        input  busy, done, bus_oe, bus, fsm_state
    );
    modport slave (
        input  start, tx_data,
        output busy, done, bus_oe, bus, fsm_state
    );
`endif
endinterface

// File: rtl/onewire_word_tx.sv
// 1-Wire master word engine: sends DATA_W bits LSB first as write-1/write-0 slots.
// Optional macro ONEWIRE_READ_EN adds read slots that sample bus_in into rd_data.
module onewire_word_tx #(
    parameter int DATA_W     = 8,
    parameter int SLOT_CYC   = 60,
    parameter int LOW1_CYC   = 6,
    parameter int REC_CYC    = 11,
    parameter int SAMPLE_CYC = 13
) (
    input  logic               clk,
    input  logic               rst,
    onewire_word_tx_if.slave   ow
);
    localparam int CNT_MAX = (SLOT_CYC > REC_CYC) ? SLOT_CYC : REC_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(REC_CYC - 1);
    localparam logic [CNT_W-1:0] LOW1_LEN  = CNT_W'(LOW1_CYC);
    localparam logic [CNT_W-1:0] LOW0_LEN  = CNT_W'(SLOT_CYC);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    generate
        if (!(LOW1_CYC >= 1 && LOW1_CYC < SAMPLE_CYC && SAMPLE_CYC < SLOT_CYC &&
              REC_CYC >= 1 && DATA_W >= 1 && DATA_W <= 32)) begin : g_bad_cfg
            $error("onewire_word_tx: illegal DATA_W or slot timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, SLOT = 2'd1, REC = 2'd2, FIN = 2'd3} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  low_len;
    logic              slot_end;
    logic              rec_end;
    logic              last_bit;

    assign slot_end = (cyc_cnt == SLOT_LAST);
    assign rec_end  = (cyc_cnt == REC_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

`ifdef ONEWIRE_READ_EN
    logic              rd_q;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_next;

    // Read slots always use the short low pulse so the slave can drive the line.
    assign low_len = (rd_q || shreg[0]) ? LOW1_LEN : LOW0_LEN;

    always_comb begin
        rd_next = rd_shift >> 1;
        rd_next[DATA_W-1] = ow.bus_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= 1'b0;
            rd_shift <= '0;
        end else if (state == IDLE && ow.start) begin
            rd_q     <= ow.rd_mode;
            rd_shift <= '0;
        end else if (state == SLOT && rd_q && cyc_cnt == CNT_W'(SAMPLE_CYC)) begin
            rd_shift <= rd_next;
        end
    end

    assign ow.rd_data = rd_shift;
`else
    assign low_len = shreg[0] ? LOW1_LEN : LOW0_LEN;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ow.start) state_nxt = SLOT;
            SLOT:    if (slot_end) state_nxt = REC;
            REC:     if (rec_end)  state_nxt = last_bit ? FIN : SLOT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ow.busy      = (state == SLOT) || (state == REC);
        ow.done      = (state == FIN);
        ow.bus_oe    = (state == SLOT) && (cyc_cnt < low_len);
        ow.fsm_state = state;
    end

    assign ow.bus = ow.bus_oe ? 1'b0 : 1'bz;

    // cyc_cnt restarts at 0 on every SLOT/REC entry; the word shifts once per finished bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    if (ow.start) begin
                        shreg   <= ow.tx_data;
                        bit_cnt <= '0;
                    end
                end
                SLOT: cyc_cnt <= slot_end ? '0 : cyc_cnt + 1'b1;
                REC: begin
                    if (rec_end) begin
                        cyc_cnt <= '0;
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: cyc_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_word_tx.sv
// Bench for onewire_word_tx: directed words, pulse widths and done timing checked by a scoreboard.
// Define ONEWIRE_READ_EN to also exercise the read-slot path.
module tb_onewire_word_tx;
  localparam int DATA_W     = 8;
  localparam int SLOT_CYC   = 60;
  localparam int LOW1_CYC   = 6;
  localparam int REC_CYC    = 11;
  localparam int SAMPLE_CYC = 13;
  localparam int PERIOD     = SLOT_CYC + REC_CYC;
  // done is high in the cycle whose closing edge is accept + DATA_W*PERIOD + 1
  localparam int DONE_LAT   = DATA_W * PERIOD + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  onewire_word_tx_if #(.DATA_W(DATA_W)) ow ();

  onewire_word_tx #(
    .DATA_W(DATA_W), .SLOT_CYC(SLOT_CYC), .LOW1_CYC(LOW1_CYC),
    .REC_CYC(REC_CYC), .SAMPLE_CYC(SAMPLE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ow(ow)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  int overlap = 0;
  logic [31:0] exp_q[$];
  logic [31:0] first_q[$];
  logic [31:0] done_q[$];
`ifdef ONEWIRE_READ_EN
  logic [32:0] rd_q[$];
  logic        rd_active = 1'b0;
  int          rd_acc = 0;
  logic [DATA_W-1:0] rd_pat = 8'hA5;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, want, cyc);
    end
  endtask

  // driver tasks: caller is at a negedge; pre = edges on which start is expected to be ignored
  task automatic send(input logic [DATA_W-1:0] data, input int pre, output int acc);
    ow.start   = 1'b1;
    ow.tx_data = data;
    repeat (pre + 1) @(posedge clk);
    #1;
    ow.start = 1'b0;
    acc = cyc;
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] data, input int acc, input logic rd,
                             input logic [DATA_W-1:0] rd_val);
    for (int i = 0; i < DATA_W; i++)
      exp_q.push_back((rd || data[i]) ? 32'(LOW1_CYC) : 32'(SLOT_CYC));
    first_q.push_back(32'(acc));
    done_q.push_back(32'(acc + DONE_LAT));
`ifdef ONEWIRE_READ_EN
    rd_q.push_back({rd, 32'(rd_val)});
`else
    if (rd && rd_val != 0) $display("note: read expectation ignored in write-only build");
`endif
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ow.done && n < limit);
    if (!ow.done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

`ifdef ONEWIRE_READ_EN
  initial forever begin
    @(negedge clk);
    if (rd_active && (cyc - rd_acc) / PERIOD < DATA_W)
      ow.bus_in = rd_pat[(cyc - rd_acc) / PERIOD];
    else
      ow.bus_in = 1'b1;
  end
`endif

  // monitor: pops expectations whenever the DUT shows a pulse edge or done
  initial begin
    logic        prev_oe = 1'b0;
    logic        prev_busy = 1'b0;
    int          rise_cyc = 0;
    int          last_rise = 0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (ow.busy && ow.done) overlap++;
      if (ow.bus_oe && !prev_oe) begin
        if (!prev_busy) begin
          if (first_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL first_slot: unexpected transaction at cyc %0d", cyc);
          end else begin
            e = first_q.pop_front();
            check("first_slot_start", 32'(cyc), e);
          end
        end else begin
          check("slot_spacing", 32'(cyc - last_rise), 32'(PERIOD));
        end
        last_rise = cyc;
        rise_cyc  = cyc;
      end
      if (!ow.bus_oe && prev_oe) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pulse_width: unexpected pulse of %0d cycles", cyc - rise_cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_width", 32'(cyc - rise_cyc), e);
        end
      end
      if (ow.done) begin
        if (done_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL done_time: unexpected done at cyc %0d", cyc);
        end else begin
          e = done_q.pop_front();
          check("done_time", 32'(cyc + 1), e);
        end
`ifdef ONEWIRE_READ_EN
        if (rd_q.size() != 0) begin
          logic [32:0] r;
          r = rd_q.pop_front();
          if (r[32]) check("rd_data", 32'(ow.rd_data), r[31:0]);
        end
`endif
      end
      prev_oe   = ow.bus_oe;
      prev_busy = ow.busy;
    end
  end

  // stimulus
  initial begin
    int acc;
    int idle_bad;
    ow.start   = 1'b0;
    ow.tx_data = '0;
`ifdef ONEWIRE_READ_EN
    ow.rd_mode = 1'b0;
    ow.bus_in  = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ow.bus_oe || ow.busy || ow.done) idle_bad++;
    end
    check("idle_after_reset", 32'(idle_bad), 32'd0);

    // 0x33 with a stray start and changed tx_data at cycle 200
    send(8'h33, 0, acc);
    expect_word(8'h33, acc, 1'b0, '0);
    while (cyc < acc + 200) @(negedge clk);
    ow.start = 1'b1; ow.tx_data = 8'hCC;
    @(negedge clk);
    ow.start = 1'b0;
    wait_done(1000);

    // 0x00 then 0xFF, second start raised during the done cycle and held one more
    @(negedge clk);
    send(8'h00, 0, acc);
    expect_word(8'h00, acc, 1'b0, '0);
    wait_done(1000);
    send(8'hFF, 1, acc);
    expect_word(8'hFF, acc, 1'b0, '0);
    wait_done(1000);

    // reset during the long low of bit 1 of 0xA4
    @(negedge clk);
    @(negedge clk);
    send(8'hA4, 0, acc);
    exp_q.push_back(32'(SLOT_CYC));
    exp_q.push_back(32'(100 - PERIOD));
    first_q.push_back(32'(acc));
`ifdef ONEWIRE_READ_EN
    rd_q.push_back(33'd0);
`endif
    while (cyc < acc + 99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(ow.busy), 32'd0);
    check("rst_bus_oe", 32'(ow.bus_oe), 32'd0);
    check("rst_done", 32'(ow.done), 32'd0);
    rst = 1'b0;
`ifdef ONEWIRE_READ_EN
    void'(rd_q.pop_back());
`endif
    repeat (20) @(negedge clk);
    send(8'hA4, 0, acc);
    expect_word(8'hA4, acc, 1'b0, '0);
    wait_done(1000);

`ifdef ONEWIRE_READ_EN
    // read slots returning 0xA5; tx_data would give long lows if it were used
    @(negedge clk);
    ow.rd_mode = 1'b1;
    send(8'h00, 0, acc);
    rd_acc = acc;
    rd_active = 1'b1;
    ow.rd_mode = 1'b0;
    expect_word(8'h00, acc, 1'b1, 8'hA5);
    wait_done(1000);
    rd_active = 1'b0;
`endif

    repeat (10) @(negedge clk);
    check("busy_done_overlap", 32'(overlap), 32'd0);
    check("pending_pulses", 32'(exp_q.size() + done_q.size() + first_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
